sram_stream_reader: RTL and testbench

- Initiator for the single-port SRAM macro interface (req/we/addr/wdata/be in, rdata out, fixed read latency, no grant).
- Accepts a burst command (start word address, word count) and issues back-to-back reads.
- Returns read data as a valid/ready stream with a last flag.
- A credit-limited internal FIFO absorbs the fixed-latency returns, so downstream backpressure never drops data.
- Sits between cluster DMA/streaming logic and any SRAM wrapper instance.

---
 rtl/sram_stream_reader_pkg.sv | 14 +
 rtl/sram_stream_reader_fifo.sv | 61 ++++++
 rtl/sram_stream_reader.sv | 161 ++++++++++++++++
 tb/tb_sram_stream_reader.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_reader_pkg.sv
// rtl/sram_stream_reader_pkg.sv - shared types and constants for sram_stream_reader
// Contents: burst FSM state encoding, legal read-latency bounds.
package sram_stream_reader_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sram_stream_reader_fifo.sv
// rtl/sram_stream_reader_fifo.sv - registered-output FIFO buffering SRAM read returns
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  write side; a push while full is accepted only together with a pop
//   pop_i, data_o   read side; data_o is the head entry, forced to 0 while empty
//   full_o, empty_o, count_o  occupancy status
module sram_stream_reader_fifo
    import sram_stream_reader_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntWidth = $clog2(Depth + 1);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                do_push, do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntWidth'(Depth));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CntWidth'(1);
            else if (do_pop && !do_push) count_q <= count_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - burst reader: SRAM read requests in, valid/ready stream out
// Optional feature macro: SRAM_STREAM_READER_USER_EN (carry mem_ruser_i through to out_user_o).
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   cmd_*          burst command: start word address and word count (count 0 is a no-op)
//   busy_o         high from command accept until the final beat is handed off
//   mem_*          single-port SRAM initiator side, read-only, fixed read latency
//   out_*          read data stream with last flag (and user sideband when enabled)
module sram_stream_reader
    import sram_stream_reader_pkg::*;
#(
    parameter int DataWidth = 64,
    parameter int UserWidth = 1,
    parameter int NumWords  = 1024,
    parameter int Latency   = 1,
    parameter int FifoDepth = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [$clog2(NumWords)-1:0]   cmd_addr_i,
    input  logic [$clog2(NumWords):0]     cmd_len_i,
    output logic                          busy_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [$clog2(NumWords)-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]          mem_wdata_o,
    output logic [(DataWidth+7)/8-1:0]    mem_be_o,
    input  logic [DataWidth-1:0]          mem_rdata_i,
    input  logic [UserWidth-1:0]          mem_ruser_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DataWidth-1:0]          out_data_o,
    output logic [UserWidth-1:0]          out_user_o,
    output logic                          out_last_o
);

    localparam int AddrWidth = $clog2(NumWords);
    localparam int CntWidth  = $clog2(FifoDepth + 1);
    localparam int SumWidth  = CntWidth + 1;

    if (Latency < LATENCY_MIN || Latency > LATENCY_MAX) begin : g_bad_latency
        $error("sram_stream_reader: Latency must be 1 or 2");
    end
    if (FifoDepth < Latency + 1) begin : g_bad_depth
        $error("sram_stream_reader: FifoDepth must be at least Latency+1");
    end

`ifdef SRAM_STREAM_READER_USER_EN
    localparam int EntryWidth = DataWidth + 1 + UserWidth;
`else
    localparam int EntryWidth = DataWidth + 1;
`endif

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_next;
    logic [AddrWidth:0]     remaining_q;
    logic [CntWidth-1:0]    inflight_q, fifo_count;
    logic [Latency-1:0]     tag_valid_q, tag_last_q;
    logic [EntryWidth-1:0]  push_data, pop_data;
    logic                   cmd_fire, out_fire, credit_ok, last_req;
    logic                   ret_valid, ret_last, fifo_empty, fifo_full_unused;

    assign cmd_fire  = cmd_valid_i && cmd_ready_o;
    assign out_fire  = out_valid_o && out_ready_i;
    assign ret_valid = tag_valid_q[Latency-1];
    assign ret_last  = tag_last_q[Latency-1];
    assign last_req  = mem_req_o && (remaining_q == (AddrWidth+1)'(1));
    assign addr_next = (addr_q == AddrWidth'(NumWords - 1)) ? '0 : addr_q + AddrWidth'(1);

    // Every outstanding request owns a FIFO slot. A pop in this cycle frees a slot
    // before any data this request could return, so it counts as a credit; this is
    // what sustains one word per cycle at FifoDepth == Latency+1.
    assign credit_ok = (SumWidth'(inflight_q) + SumWidth'(fifo_count))
                     < (SumWidth'(FifoDepth) + SumWidth'(out_fire));

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        mem_req_o   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_o = rst_ni;
                if (cmd_valid_i && rst_ni && cmd_len_i != '0) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                mem_req_o = (remaining_q != '0) && credit_ok;
                if (mem_req_o && remaining_q == (AddrWidth+1)'(1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_fire && out_last_o) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= '0;
            tag_valid_q <= '0;
            tag_last_q  <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_fire) begin
                addr_q      <= cmd_addr_i;
                remaining_q <= cmd_len_i;
            end else if (mem_req_o) begin
                addr_q      <= addr_next;
                remaining_q <= remaining_q - (AddrWidth+1)'(1);
            end
            if (mem_req_o && !ret_valid)      inflight_q <= inflight_q + CntWidth'(1);
            else if (ret_valid && !mem_req_o) inflight_q <= inflight_q - CntWidth'(1);
            // Tag pipeline mirrors the SRAM latency; the last stage marks valid rdata.
            tag_valid_q[0] <= mem_req_o;
            tag_last_q[0]  <= last_req;
            for (int i = 1; i < Latency; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_last_q[i]  <= tag_last_q[i-1];
            end
        end
    end

`ifdef SRAM_STREAM_READER_USER_EN
    assign push_data  = {mem_ruser_i, ret_last, mem_rdata_i};
    assign out_user_o = pop_data[DataWidth+1 +: UserWidth];
`else
    logic unused_ruser;
    assign unused_ruser = ^mem_ruser_i;
    assign push_data    = {ret_last, mem_rdata_i};
    assign out_user_o   = '0;
`endif

    sram_stream_reader_fifo #(
        .Width (EntryWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (ret_valid),
        .data_i  (push_data),
        .pop_i   (out_fire),
        .data_o  (pop_data),
        .full_o  (fifo_full_unused),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid_o = !fifo_empty;
    assign out_data_o  = pop_data[DataWidth-1:0];
    assign out_last_o  = pop_data[DataWidth];
    assign busy_o      = (state_q != ST_IDLE);
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = 1'b0;
    assign mem_wdata_o = '0;
    assign mem_be_o    = '1;

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - randomized self-checking bench for sram_stream_reader
module tb_sram_stream_reader;

    localparam int NW      = 1024;
    localparam int A_DEPTH = 4;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [63:0] mem [NW];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: Latency 1, FifoDepth 4
    logic        a_cmd_valid, a_cmd_ready, a_busy, a_mem_req, a_mem_we;
    logic [9:0]  a_cmd_addr, a_mem_addr;
    logic [10:0] a_cmd_len;
    logic [63:0] a_mem_wdata, a_rdata, a_out_data;
    logic [7:0]  a_mem_be;
    logic        a_out_valid, a_out_ready, a_out_last;
    logic [0:0]  a_out_user;

    // DUT B: Latency 2, FifoDepth 3
    logic        b_cmd_valid, b_cmd_ready, b_busy, b_mem_req, b_mem_we;
    logic [9:0]  b_cmd_addr, b_mem_addr;
    logic [10:0] b_cmd_len;
    logic [63:0] b_mem_wdata, b_stage, b_rdata, b_out_data;
    logic [7:0]  b_mem_be;
    logic        b_out_valid, b_out_ready, b_out_last;
    logic [0:0]  b_out_user;

    sram_stream_reader dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(a_cmd_valid), .cmd_ready_o(a_cmd_ready),
        .cmd_addr_i(a_cmd_addr), .cmd_len_i(a_cmd_len), .busy_o(a_busy),
        .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
        .mem_wdata_o(a_mem_wdata), .mem_be_o(a_mem_be),
        .mem_rdata_i(a_rdata), .mem_ruser_i(1'b0),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .out_data_o(a_out_data), .out_user_o(a_out_user), .out_last_o(a_out_last)
    );

    sram_stream_reader #(.Latency(2), .FifoDepth(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready),
        .cmd_addr_i(b_cmd_addr), .cmd_len_i(b_cmd_len), .busy_o(b_busy),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_be_o(b_mem_be),
        .mem_rdata_i(b_rdata), .mem_ruser_i(1'b0),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .out_data_o(b_out_data), .out_user_o(b_out_user), .out_last_o(b_out_last)
    );

    // SRAM models: fixed read latency of 1 (A) and 2 (B)
    always @(posedge clk) begin
        if (a_mem_req) a_rdata <= mem[a_mem_addr];
        if (b_mem_req) b_stage <= mem[b_mem_addr];
        b_rdata <= b_stage;
    end

    // Observed traffic, sampled on the falling edge
    int          a_req_addr[$], a_req_cyc[$], a_beat_cyc[$];
    logic [63:0] a_beat_data[$];
    bit          a_beat_last[$];
    int          b_req_addr[$], b_req_cyc[$], b_beat_cyc[$];
    logic [63:0] b_beat_data[$];
    bit          b_beat_last[$];
    int          a_hold_viol = 0;
    bit          a_prev_stall = 0;
    logic [63:0] a_prev_data;
    bit          a_prev_last;

    always @(negedge clk) begin
        cyc++;
        if (a_mem_req) begin a_req_addr.push_back(int'(a_mem_addr)); a_req_cyc.push_back(cyc); end
        if (a_out_valid && a_out_ready) begin
            a_beat_data.push_back(a_out_data); a_beat_last.push_back(a_out_last); a_beat_cyc.push_back(cyc);
        end
        if (b_mem_req) begin b_req_addr.push_back(int'(b_mem_addr)); b_req_cyc.push_back(cyc); end
        if (b_out_valid && b_out_ready) begin
            b_beat_data.push_back(b_out_data); b_beat_last.push_back(b_out_last); b_beat_cyc.push_back(cyc);
        end
        if (a_prev_stall && rst_n &&
            (!a_out_valid || a_out_data !== a_prev_data || a_out_last !== a_prev_last))
            a_hold_viol++;
        a_prev_stall = a_out_valid && !a_out_ready && rst_n;
        a_prev_data  = a_out_data;
        a_prev_last  = a_out_last;
    end

    task automatic clear_a();
        a_req_addr.delete(); a_req_cyc.delete(); a_beat_cyc.delete();
        a_beat_data.delete(); a_beat_last.delete();
    endtask

    // mode 0: ready held high; 1: random ready; 2: ready low for 10 cycles after first beat
    task automatic run_a(input int addr, input int len, input int mode, input int stop,
                         output bit timeout, output bit busy_seen, output bit busy_after,
                         output int snap);
        int stall = 0;
        clear_a();
        timeout = 0; snap = -1; busy_after = 1;
        a_out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        a_cmd_valid = 1'b1; a_cmd_addr = 10'(addr); a_cmd_len = 11'(len);
        if (!a_cmd_ready) timeout = 1;
        @(posedge clk); #1;
        a_cmd_valid = 1'b0;
        busy_seen = a_busy;
        for (int c = 0; c < 2000 && a_beat_data.size() < stop; c++) begin
            case (mode)
                1: a_out_ready = ($urandom_range(0, 3) != 0);
                2: if (a_beat_data.size() >= 1 && stall < 10) begin
                       a_out_ready = 1'b0; stall++;
                   end else begin
                       if (stall == 10 && snap < 0) snap = a_req_addr.size();
                       a_out_ready = 1'b1;
                   end
                default: a_out_ready = 1'b1;
            endcase
            @(posedge clk); #1;
        end
        if (a_beat_data.size() < stop) timeout = 1;
        if (stop == len) begin
            busy_after = a_busy;
            a_out_ready = 1'b1;
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_cmd_valid = 0; a_cmd_addr = 0; a_cmd_len = 0; a_out_ready = 0;
        b_cmd_valid = 0; b_cmd_addr = 0; b_cmd_len = 0; b_out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({a_cmd_ready, a_busy, a_mem_req, a_out_valid, a_out_last} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00000",
                            {a_cmd_ready, a_busy, a_mem_req, a_out_valid, a_out_last});
        end
        total++;
        if (a_out_data !== 64'd0 || a_mem_addr !== 10'd0 || a_out_user !== 1'b0) begin
            bad++; $display("FAIL reset_data data=%h addr=%h user=%b exp=0", a_out_data, a_mem_addr, a_out_user);
        end
        total++;
        if (a_mem_we !== 1'b0 || a_mem_wdata !== 64'd0 || a_mem_be !== 8'hff) begin
            bad++; $display("FAIL tieoffs we=%b wdata=%h be=%h exp=0/0/ff", a_mem_we, a_mem_wdata, a_mem_be);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (a_cmd_ready !== 1'b1 || b_cmd_ready !== 1'b1) begin
            bad++; $display("FAIL idle_cmd_ready a=%b b=%b exp=1", a_cmd_ready, b_cmd_ready);
        end
    endtask

    task automatic test_basic();
        bit to, bs, ba; int snap;
        run_a(16, 4, 0, 4, to, bs, ba, snap);
        total++;
        if (to || a_req_addr.size() != 4 || a_beat_data.size() != 4) begin
            bad++; $display("FAIL basic_count to=%0d reqs=%0d beats=%0d exp=4", to, a_req_addr.size(), a_beat_data.size());
        end
        total++;
        if (a_req_addr.size() == 4 && a_req_cyc[3] - a_req_cyc[0] != 3) begin
            bad++; $display("FAIL basic_req_span got=%0d exp=3", a_req_cyc[3] - a_req_cyc[0]);
        end
        total++;
        if (bs !== 1'b1 || ba !== 1'b0) begin
            bad++; $display("FAIL basic_busy during=%b after=%b exp=1/0", bs, ba);
        end
        for (int i = 0; i < 4 && i < a_req_addr.size() && i < a_beat_data.size(); i++) begin
            total++;
            if (a_req_addr[i] != 16 + i || a_beat_data[i] !== mem[16 + i] || a_beat_last[i] != (i == 3)) begin
                bad++; $display("FAIL basic_beat[%0d] addr=%0d data=%h last=%0d exp addr=%0d data=%h",
                                i, a_req_addr[i], a_beat_data[i], a_beat_last[i], 16 + i, mem[16 + i]);
            end
        end
    endtask

    task automatic test_zero_len();
        int viol = 0;
        clear_a();
        a_out_ready = 1'b1;
        a_cmd_valid = 1'b1; a_cmd_addr = 10'd5; a_cmd_len = 11'd0;
        total++;
        if (a_cmd_ready !== 1'b1) begin bad++; $display("FAIL zero_cmd_ready got=%b exp=1", a_cmd_ready); end
        @(posedge clk); #1;
        a_cmd_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (a_busy !== 1'b0 || a_cmd_ready !== 1'b1) viol++;
            @(posedge clk); #1;
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL zero_busy_ready violations=%0d exp=0", viol); end
        total++;
        if (a_req_addr.size() != 0 || a_beat_data.size() != 0) begin
            bad++; $display("FAIL zero_traffic reqs=%0d beats=%0d exp=0", a_req_addr.size(), a_beat_data.size());
        end
    endtask

    task automatic test_wrap();
        bit to, bs, ba; int snap; int exp_addr;
        run_a(NW - 2, 4, 0, 4, to, bs, ba, snap);
        total++;
        if (to || a_req_addr.size() != 4 || a_beat_data.size() != 4) begin
            bad++; $display("FAIL wrap_count to=%0d reqs=%0d beats=%0d exp=4", to, a_req_addr.size(), a_beat_data.size());
        end
        for (int i = 0; i < 4 && i < a_req_addr.size() && i < a_beat_data.size(); i++) begin
            exp_addr = (NW - 2 + i) % NW;
            total++;
            if (a_req_addr[i] != exp_addr || a_beat_data[i] !== mem[exp_addr]) begin
                bad++; $display("FAIL wrap_beat[%0d] addr=%0d data=%h exp addr=%0d data=%h",
                                i, a_req_addr[i], a_beat_data[i], exp_addr, mem[exp_addr]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to, bs, ba; int snap; int addr; int exp_addr;
        addr = $urandom_range(0, NW - 1);
        a_hold_viol = 0;
        run_a(addr, 16, 2, 16, to, bs, ba, snap);
        total++;
        if (to || a_req_addr.size() != 16 || a_beat_data.size() != 16) begin
            bad++; $display("FAIL bp_count to=%0d reqs=%0d beats=%0d exp=16", to, a_req_addr.size(), a_beat_data.size());
        end
        total++;
        if (snap != 1 + A_DEPTH) begin bad++; $display("FAIL bp_credit reqs_at_stall_end=%0d exp=%0d", snap, 1 + A_DEPTH); end
        total++;
        if (a_hold_viol != 0) begin bad++; $display("FAIL bp_hold_stable violations=%0d exp=0", a_hold_viol); end
        for (int i = 0; i < 16 && i < a_beat_data.size(); i++) begin
            exp_addr = (addr + i) % NW;
            total++;
            if (a_beat_data[i] !== mem[exp_addr] || a_beat_last[i] != (i == 15)) begin
                bad++; $display("FAIL bp_beat[%0d] data=%h last=%0d exp data=%h", i, a_beat_data[i], a_beat_last[i], mem[exp_addr]);
            end
        end
    endtask

    task automatic test_latency2();
        int addr; int exp_addr;
        addr = $urandom_range(0, NW - 1);
        b_req_addr.delete(); b_req_cyc.delete(); b_beat_cyc.delete();
        b_beat_data.delete(); b_beat_last.delete();
        b_out_ready = 1'b1;
        b_cmd_valid = 1'b1; b_cmd_addr = 10'(addr); b_cmd_len = 11'd8;
        total++;
        if (b_cmd_ready !== 1'b1) begin bad++; $display("FAIL lat2_cmd_ready got=%b exp=1", b_cmd_ready); end
        @(posedge clk); #1;
        b_cmd_valid = 1'b0;
        for (int c = 0; c < 100 && b_beat_data.size() < 8; c++) begin
            @(posedge clk); #1;
        end
        total++;
        if (b_req_addr.size() != 8 || b_beat_data.size() != 8) begin
            bad++; $display("FAIL lat2_count reqs=%0d beats=%0d exp=8", b_req_addr.size(), b_beat_data.size());
        end else begin
            total++;
            if (b_req_cyc[7] - b_req_cyc[0] != 7 || b_beat_cyc[7] - b_beat_cyc[0] != 7) begin
                bad++; $display("FAIL lat2_throughput req_span=%0d beat_span=%0d exp=7",
                                b_req_cyc[7] - b_req_cyc[0], b_beat_cyc[7] - b_beat_cyc[0]);
            end
            total++;
            if (b_beat_cyc[0] - b_req_cyc[0] != 3) begin
                bad++; $display("FAIL lat2_first_beat got=%0d exp=3", b_beat_cyc[0] - b_req_cyc[0]);
            end
            for (int i = 0; i < 8; i++) begin
                exp_addr = (addr + i) % NW;
                total++;
                if (b_req_addr[i] != exp_addr || b_beat_data[i] !== mem[exp_addr] || b_beat_last[i] != (i == 7)) begin
                    bad++; $display("FAIL lat2_beat[%0d] addr=%0d data=%h exp addr=%0d data=%h",
                                    i, b_req_addr[i], b_beat_data[i], exp_addr, mem[exp_addr]);
                end
            end
        end
        total++;
        if (b_busy !== 1'b0 || b_mem_we !== 1'b0 || b_mem_wdata !== 64'd0 || b_mem_be !== 8'hff || b_out_user !== 1'b0) begin
            bad++; $display("FAIL lat2_idle busy=%b we=%b be=%h exp=0/0/ff", b_busy, b_mem_we, b_mem_be);
        end
    endtask

    task automatic test_reset_mid();
        bit to, bs, ba; int snap; int addr; int exp_addr;
        run_a($urandom_range(0, NW - 1), 8, 0, 3, to, bs, ba, snap);
        total++;
        if (to || a_out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid to=%0d valid=%b exp=1", to, a_out_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({a_out_valid, a_mem_req, a_busy, a_out_last, a_cmd_ready} !== 5'b0 || a_out_data !== 64'd0) begin
            bad++; $display("FAIL mid_reset_outputs got=%b data=%h exp=0",
                            {a_out_valid, a_mem_req, a_busy, a_out_last, a_cmd_ready}, a_out_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        addr = $urandom_range(0, NW - 1);
        run_a(addr, 2, 0, 2, to, bs, ba, snap);
        total++;
        if (to || a_beat_data.size() != 2 || a_req_addr.size() != 2) begin
            bad++; $display("FAIL mid_after_count to=%0d beats=%0d reqs=%0d exp=2", to, a_beat_data.size(), a_req_addr.size());
        end
        for (int i = 0; i < 2 && i < a_beat_data.size(); i++) begin
            exp_addr = (addr + i) % NW;
            total++;
            if (a_beat_data[i] !== mem[exp_addr] || a_beat_last[i] != (i == 1)) begin
                bad++; $display("FAIL mid_after_beat[%0d] data=%h last=%0d exp data=%h", i, a_beat_data[i], a_beat_last[i], mem[exp_addr]);
            end
        end
    endtask

    task automatic test_random();
        bit to, bs, ba; int snap; int addr, len, exp_addr, errs;
        a_hold_viol = 0;
        for (int t = 0; t < 6; t++) begin
            addr = $urandom_range(0, NW - 1);
            len  = $urandom_range(1, 24);
            run_a(addr, len, 1, len, to, bs, ba, snap);
            total++;
            if (to || ba !== 1'b0 || a_req_addr.size() != len || a_beat_data.size() != len) begin
                bad++; $display("FAIL rand%0d_count to=%0d busy_after=%b reqs=%0d beats=%0d exp=%0d",
                                t, to, ba, a_req_addr.size(), a_beat_data.size(), len);
            end
            errs = 0;
            for (int i = 0; i < len && i < a_req_addr.size() && i < a_beat_data.size(); i++) begin
                exp_addr = (addr + i) % NW;
                if (a_req_addr[i] != exp_addr || a_beat_data[i] !== mem[exp_addr] || a_beat_last[i] != (i == len - 1))
                    errs++;
            end
            total++;
            if (errs != 0) begin bad++; $display("FAIL rand%0d_beats wrong=%0d exp=0 (addr=%0d len=%0d)", t, errs, addr, len); end
        end
        total++;
        if (a_hold_viol != 0) begin bad++; $display("FAIL rand_hold_stable violations=%0d exp=0", a_hold_viol); end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) mem[i] = {$urandom, $urandom};
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_backpressure();
        test_latency2();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
